// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way arbiter: requester count, id width, FSM states.
// The optional fixed-priority mode is selected by the macro ARB_FIXED_PRIO_EN.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encoder: the first active request at or after ptr (mod 4) wins.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_shift;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W-1:0]    w_off;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign w_dbl   = {req, req};
    assign w_shift = w_dbl >> ptr;
    assign w_rot   = w_shift[N_REQ-1:0];

    always_comb begin
        w_off = '0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign id  = w_off + ptr;
    assign any = |req;

endmodule

// File: rtl/arbiter_4.sv
// Round-robin 4-requester arbiter with a MAX_HOLD grant limit and timeout pulse.
// Define ARB_FIXED_PRIO_EN to pin the priority pointer at 0 (fixed priority, 0 highest).
module arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HW       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic             r_timeout;
    logic [ID_W-1:0]  r_ptr;
    logic [HW-1:0]    r_hold_cnt;

    logic [ID_W-1:0]  w_pick_id;
    logic             w_pick_any;
    logic [ID_W-1:0]  w_ptr_adv;

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .id  (w_pick_id),
        .any (w_pick_any)
    );

`ifdef ARB_FIXED_PRIO_EN
    assign w_ptr_adv = '0;
`else
    assign w_ptr_adv = r_gnt_id + 2'd1;
`endif

    // Every grant ends in IDLE, so new winners are only chosen from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_state    <= GRANT;
                        r_gnt      <= id_to_onehot(w_pick_id);
                        r_gnt_id   <= w_pick_id;
                        r_hold_cnt <= HW'(1);
                    end else begin
                        r_gnt <= '0;
                    end
                end
                GRANT: begin
                    if (!req[r_gnt_id]) begin
                        r_state    <= IDLE;
                        r_gnt      <= '0;
                        r_ptr      <= w_ptr_adv;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HW'(MAX_HOLD)) begin
                        r_state    <= IDLE;
                        r_gnt      <= '0;
                        r_ptr      <= w_ptr_adv;
                        r_hold_cnt <= '0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_arbiter_4.sv
// Directed bench for arbiter_4 (MAX_HOLD=4); inputs driven and outputs sampled on negedge.
// Round-robin scenarios run by default; fixed-priority ones when ARB_FIXED_PRIO_EN is defined.
module tb_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    arbiter_4 #(.MAX_HOLD(4), .HW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step(); step();
        checks++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: gnt=%b id=%0d valid=%b to=%b, required 0000/0/0/0", gnt, gnt_id, gnt_valid, timeout);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: gnt=%b to=%b, required 0000/0", gnt, timeout);
        end
        $display("reset: gnt=%b id=%0d valid=%b", gnt, gnt_id, gnt_valid);
    endtask

    task automatic test_rotation();
        logic [3:0] drive [0:4];
        logic [3:0] expg  [0:4];
        logic [1:0] expid [0:4];
        drive = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0111};
        expg  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        expid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = drive[0];
        step();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                req = drive[i];
                step();
                checks++;
                if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rot_gap%0d: gnt=%b valid=%b, required 0000/0", i, gnt, gnt_valid);
                end
                step();
            end
            checks++;
            if (gnt !== expg[i] || gnt_id !== expid[i] || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rot_grant%0d: gnt=%b id=%0d valid=%b, required %b/%0d/1", i, gnt, gnt_id, gnt_valid, expg[i], expid[i]);
            end
            $display("rotation %0d: req=%b gnt=%b id=%0d", i, req, gnt, gnt_id);
        end
        req = 4'b0000;
        step(); step();
    endtask

    task automatic test_skip();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 4'b1010;
        step();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL skip_first: gnt=%b id=%0d, required 0010/1", gnt, gnt_id);
        end
        req = 4'b1000;
        step();
        req = 4'b1010;
        step();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL skip_second: gnt=%b id=%0d, required 1000/3", gnt, gnt_id);
        end
        $display("skip: gnt=%b id=%0d", gnt, gnt_id);
        req = 4'b0000;
        step(); step();
    endtask

    task automatic test_timeout();
        req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (gnt !== 4'b0100 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: gnt=%b to=%b, required 0100/0", c, gnt, timeout);
            end
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: gnt=%b to=%b valid=%b, required 0000/1/0", gnt, timeout, gnt_valid);
        end
        step();
        checks++;
        if (gnt !== 4'b0100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL regrant: gnt=%b to=%b, required 0100/0", gnt, timeout);
        end
        $display("timeout: regranted gnt=%b", gnt);
`ifndef ARB_FIXED_PRIO_EN
        // Owner 2 times out with 1 also waiting: ptr=3 ranks 1 ahead of 2.
        req = 4'b0110;
        step(); step(); step(); step();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout2_pulse: gnt=%b to=%b, required 0000/1", gnt, timeout);
        end
        step();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL timeout_rank: gnt=%b id=%0d, required 0010/1", gnt, gnt_id);
        end
        $display("timeout rank: gnt=%b id=%0d", gnt, gnt_id);
`endif
        req = 4'b0000;
        step(); step();
    endtask

    task automatic test_release_at_limit();
        logic [3:0] exp_next;
`ifdef ARB_FIXED_PRIO_EN
        exp_next = 4'b0001;
`else
        exp_next = 4'b0010;
`endif
        req = 4'b0001;
        step(); step(); step(); step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL limit_hold: gnt=%b, required 0001", gnt);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL release_at_limit: gnt=%b to=%b, required 0000/0", gnt, timeout);
        end
        req = 4'b0011;
        step();
        checks++;
        if (gnt !== exp_next) begin
            errors++;
            $display("FAIL ptr_after_release: gnt=%b, required %b", gnt, exp_next);
        end
        $display("release at limit: next gnt=%b", gnt);
        req = 4'b0000;
        step(); step();
    endtask

    task automatic test_async_reset();
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL pre_reset_grant: gnt=%b, required 0100", gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b valid=%b to=%b, required 0000/0/0", gnt, gnt_valid, timeout);
        end
        step();
        req   = 4'b1111;
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_ptr: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        end
        $display("async reset: post-reset gnt=%b", gnt);
        req = 4'b0000;
        step(); step();
    endtask

`ifdef ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        for (int r = 0; r < 4; r++) begin
            req = 4'b1110;
            step();
            checks++;
            if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
                errors++;
                $display("FAIL fixed_round%0d: gnt=%b id=%0d, required 0010/1", r, gnt, gnt_id);
            end
            req = 4'b1100;
            step();
            $display("fixed prio round %0d: gnt=0010 expected", r);
        end
        req = 4'b0000;
        step(); step();
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            req = 4'($urandom_range(0, 15));
            step();
            checks++;
            if (!$onehot0(gnt) || gnt_valid !== (|gnt)) begin
                errors++;
                bad++;
                $display("FAIL invariant%0d: gnt=%b valid=%b, required onehot0 and valid=|gnt", i, gnt, gnt_valid);
            end
        end
        req = 4'b0000;
        step();
        $display("random: 1000 cycles, %0d invariant violations", bad);
    endtask

    initial begin
        test_reset();
`ifndef ARB_FIXED_PRIO_EN
        test_rotation();
        test_skip();
`else
        test_fixed_prio();
`endif
        test_timeout();
        test_release_at_limit();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
